// File: rtl/mem_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: FSM states, owner encoding, counter width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StResp = 2'd2
  } state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnD  = 1'b1
  } owner_e;

  localparam int unsigned CntW = 4;

endpackage

// File: rtl/mem_arbiter_prio.sv
// Winner selection between fetch and data requesters, with an optional starvation guard
// compiled in by MEM_ARBITER_STARVE_GUARD_EN (strict data priority otherwise).
module mem_arbiter_prio
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic gnt_i,
  input  logic gnt_own_i,
  output logic win_o
);

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            starved;

  assign starved = (cnt_q == CntW'(STARVE_LIMIT));

  // Count data grants taken while fetch is waiting; any other grant clears the count.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt_i) begin
      if ((gnt_own_i == OwnD) && if_req_i) begin
        if (cnt_q != {CntW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    win_o = OwnIf;
    if (d_req_i && !(if_req_i && starved)) begin
      win_o = OwnD;
    end
  end
`else
  logic unused_sigs;
  assign unused_sigs = ^{clk, reset, if_req_i, gnt_i, gnt_own_i, STARVE_LIMIT[0]};

  always_comb begin
    win_o = OwnIf;
    if (d_req_i) begin
      win_o = OwnD;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and data requesters, one transaction in flight.
// Starvation guard is enabled by defining MEM_ARBITER_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);

  localparam int unsigned BeW = DATA_W / 8;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   win;
  owner_e sel_own;
  logic   req_any;
  logic   gnt;

  mem_arbiter_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk      (clk),
    .reset    (reset),
    .if_req_i (if_req_i),
    .d_req_i  (d_req_i),
    .gnt_i    (gnt),
    .gnt_own_i(sel_own),
    .win_o    (win)
  );

  // In IDLE the live winner drives the port; in HOLD the latched owner keeps it.
  always_comb begin
    sel_own = owner_q;
    req_any = 1'b0;
    unique case (state_q)
      StIdle: begin
        sel_own = owner_e'(win);
        req_any = if_req_i | d_req_i;
      end
      StHold:  req_any = 1'b1;
      default: req_any = 1'b0;
    endcase
  end

  assign mem_req_o = req_any & ~reset;
  assign gnt       = mem_req_o & mem_gnt_i;
  assign if_gnt_o  = gnt & (sel_own == OwnIf);
  assign d_gnt_o   = gnt & (sel_own == OwnD);

  always_comb begin
    if (sel_own == OwnD) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else begin
      mem_we_o    = 1'b0;
      mem_be_o    = {BeW{1'b1}};
      mem_addr_o  = if_addr_i;
      mem_wdata_o = '0;
    end
  end

  logic rsp;
  assign rsp         = (state_q == StResp) & mem_rvalid_i & ~reset;
  assign if_rvalid_o = rsp & (owner_q == OwnIf);
  assign d_rvalid_o  = rsp & (owner_q == OwnD);
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;
  assign busy_o      = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          owner_d = sel_own;
          state_d = mem_gnt_i ? StResp : StHold;
        end
      end
      StHold: begin
        if (mem_gnt_i) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (mem_rvalid_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= OwnIf;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the pipelined core. It shares one unified instruction/data memory port between the IF stage fetch requester and the MEM stage load/store requester. The arbiter allows one outstanding transaction at a time, gives data accesses priority over fetch with a bounded-starvation guard, and routes each response back to its owner. It sits between the core's fetch and data ports and the external memory.

## Interface
Parameters:
- ADDR_W, 32, address width for all ports
- DATA_W, 32, data width for all ports
- STARVE_LIMIT, 4, number of consecutive data grants, while fetch waits, after which fetch wins; legal range 1..15

Ports:
- clk  in  1  sole clock; everything is rising-edge
- reset  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  DATA_W  fetch read data
- d_req_i  in  1  data request; held with its fields stable until d_gnt_o
- d_we_i  in  1  1 = store, 0 = load
- d_be_i  in  DATA_W/8  byte enables
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_gnt_o  out  1  data request accepted this cycle
- d_rvalid_o  out  1  data response valid (load data or store acknowledge)
- d_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  request to memory
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1 / DATA_W/8 / ADDR_W / DATA_W  forwarded request fields
- mem_gnt_i  in  1  memory accepts mem_req_o this cycle
- mem_rvalid_i  in  1  exactly one pulse per accepted transaction, reads and writes alike
- mem_rdata_i  in  DATA_W  read data, valid with mem_rvalid_i
- busy_o  out  1  state is not IDLE

## Operation
- FSM states: IDLE, HOLD, RESP. Owner register: OWN_IF or OWN_D.
- IDLE: if any request is pending, pick a winner combinationally and drive mem_req_o plus the winner's fields in the same cycle.
  - mem_gnt_i=1: pulse the winner's gnt, latch the owner, go to RESP.
  - mem_gnt_i=0: latch the owner, go to HOLD.
- HOLD: keep requesting for the latched owner. A newly arriving higher-priority request does not preempt it. On mem_gnt_i, pulse the owner's gnt and go to RESP.
- RESP: mem_req_o=0 and both gnt outputs are 0. On mem_rvalid_i:
  - drive the owner's rvalid and pass mem_rdata_i to the owner's rdata, combinationally;
  - go to IDLE.
- The inactive requester's rvalid is always 0. Both rdata outputs carry mem_rdata_i unconditionally.
- mem_rvalid_i in IDLE or HOLD is ignored.
- Winner selection: d_req_i wins over if_req_i, except that fetch wins when the starvation count equals STARVE_LIMIT.
- Starvation count (4 bits, saturating):
  - +1 on each data grant while if_req_i=1;
  - cleared on a fetch grant;
  - cleared on a data grant while if_req_i=0.

## Timing
- Best case is 2 cycles per transaction: grant in cycle N, response in cycle N+1, next arbitration in cycle N+2. There is no issue in the same cycle as a response.
- Request-to-grant latency is 0 cycles when memory is idle and grants immediately.
- gnt and rvalid outputs are combinational from state and memory inputs. No registered stage is added on the response path.
- While reset=1, mem_req_o, both gnt and both rvalid outputs are forced to 0.
- After the reset edge: state=IDLE, owner=OWN_IF, count=0, busy_o=0.
- Reset mid-transaction abandons it. A late mem_rvalid_i after reset is ignored because the state is IDLE.
- Simultaneous requests in IDLE with count<STARVE_LIMIT: data wins. Fetch stays pending and is never granted in the same cycle.

## Configuration
- MEM_ARBITER_STARVE_GUARD_EN defined: the starvation counter and fetch-override rule are compiled in as described above.
- Not defined: strict data priority, the counter is absent, and STARVE_LIMIT is unused. Fetch can then wait indefinitely under continuous data requests.

## Structure
- Package mem_arbiter_pkg holds:
  - state enum (IDLE, HOLD, RESP);
  - owner encoding (OWN_IF=0, OWN_D=1);
  - counter width constant (4).
- One sub-module, mem_arbiter_prio, contains the winner selection and the starvation counter, including the macro-guarded logic.
- The top level holds the FSM, owner register and muxes.

## Test plan
- Single fetch: if_req_i=1, addr 0x100, mem_gnt_i=1, mem_rvalid_i next cycle with 0xDEADBEEF -> if_gnt_o in cycle 0, if_rvalid_o with 0xDEADBEEF in cycle 1, d_rvalid_o=0 throughout.
- Collision: both requests in the same cycle, count=0 -> d_gnt_o first (store, be=0xF, ack pulse), if_gnt_o granted in the first IDLE cycle after the data response.
- Starvation (macro on, STARVE_LIMIT=4): d_req_i held high continuously with if_req_i=1 -> 4 data grants, then if_gnt_o on the 5th arbitration, count back to 0. With the macro off, fetch is never granted.
- HOLD lock: fetch wins in IDLE, mem_gnt_i=0 for 3 cycles, d_req_i rises in cycle 1 -> mem_addr_o stays at the fetch address and if_gnt_o pulses on the grant cycle.
- Reset mid-RESP: assert reset for 1 cycle after a grant, then mem_rvalid_i arrives -> no rvalid output, busy_o=0, next request arbitrated normally.
- Spurious response: mem_rvalid_i in IDLE -> both rvalid outputs stay 0 and the state is unchanged.
